lfsr_range_gen: RTL and testbench

//  Parametrised pseudo-random generator for matrix-element fill.

---
 rtl/lfsr_range_gen.sv | 163 ++++++++++++++++
 tb/tb_lfsr_range_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_gen.sv
// lfsr_range_gen: Fibonacci LFSR (8/16/32 bit) with seed load and a request/valid
// front end that returns a value uniformly in [lo,hi] by bounded rejection sampling.
// Optional macro LFSR_LOCKUP_GUARD_EN: replaces zero seeds and recovers a zero state with SEED.
module lfsr_range_gen #(
    parameter int unsigned LFSR_W  = 16,
    parameter int unsigned OUT_W   = 4,
    parameter logic [31:0] SEED    = 32'hACE1,
    parameter int unsigned MAX_TRY = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    input  logic [OUT_W-1:0]  lo,
    input  logic [OUT_W-1:0]  hi,
    output logic              busy,
    output logic              valid,
    output logic [OUT_W-1:0]  dout,
    output logic              fallback
);

    localparam int unsigned TryW = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [TryW-1:0] TryLast = TryW'(MAX_TRY - 1);
    localparam logic [LFSR_W-1:0] SeedVal = SEED[LFSR_W-1:0];
    localparam logic [31:0] TapsAll = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                      (LFSR_W == 16) ? 32'h0000_B400 : 32'h8020_0003;
    localparam logic [LFSR_W-1:0] Taps = TapsAll[LFSR_W-1:0];

    if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 32) begin : gen_bad_width
        $error("lfsr_range_gen: LFSR_W must be 8, 16 or 32");
    end
    if (OUT_W > LFSR_W || OUT_W < 1) begin : gen_bad_out_w
        $error("lfsr_range_gen: OUT_W must be in 1..LFSR_W");
    end
    if (MAX_TRY < 1) begin : gen_bad_max_try
        $error("lfsr_range_gen: MAX_TRY must be >= 1");
    end

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    state_e            st_q, st_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0]  lo_q, lo_d;
    logic [OUT_W-1:0]  span_q, span_d;
    logic [TryW-1:0]   try_q, try_d;
    logic [OUT_W-1:0]  dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              fallback_q, fallback_d;

    logic              fb_bit;
    logic [LFSR_W-1:0] lfsr_step;
    logic [OUT_W-1:0]  mask;
    logic [OUT_W-1:0]  cand;
    logic              step_req;

    // LFSR feedback and the masked candidate drawn from the current state.
    always_comb begin
        fb_bit    = ^(lfsr_q & Taps);
        lfsr_step = {lfsr_q[LFSR_W-2:0], fb_bit};
        // Smear span downwards: smallest all-ones value covering span.
        mask = span_q;
        for (int i = 1; i < int'(OUT_W); i++) begin
            mask = mask | (mask >> i);
        end
        cand = lfsr_q[OUT_W-1:0] & mask;
    end

    // FSM next state, operand latch, result registers and LFSR next state.
    always_comb begin
        st_d       = st_q;
        lo_d       = lo_q;
        span_d     = span_q;
        try_d      = try_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        fallback_d = fallback_q;
        step_req   = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (req) begin
                    if (lo > hi) begin
                        lo_d   = hi;
                        span_d = lo - hi;
                    end else begin
                        lo_d   = lo;
                        span_d = hi - lo;
                    end
                    try_d    = '0;
                    step_req = 1'b1;
                    st_d     = StDraw;
                end
            end
            StDraw: begin
                if (cand <= span_q) begin
                    dout_d     = lo_q + cand;
                    valid_d    = 1'b1;
                    fallback_d = 1'b0;
                    st_d       = StIdle;
                end else if (try_q != TryLast) begin
                    step_req = 1'b1;
                    // A seed load replaces this step, so the attempt is not consumed.
                    if (!seed_load) begin
                        try_d = try_q + 1'b1;
                    end
                end else begin
                    dout_d     = lo_q + (cand & span_q);
                    valid_d    = 1'b1;
                    fallback_d = 1'b1;
                    st_d       = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase

        lfsr_d = lfsr_q;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (seed_load) begin
            lfsr_d = (seed_in == '0) ? SeedVal : seed_in;
        end else if (lfsr_q == '0) begin
            lfsr_d = SeedVal;
        end else if (step_req) begin
            lfsr_d = lfsr_step;
        end
`else
        if (seed_load) begin
            lfsr_d = seed_in;
        end else if (step_req) begin
            lfsr_d = lfsr_step;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= StIdle;
            lfsr_q     <= SeedVal;
            lo_q       <= '0;
            span_q     <= '0;
            try_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            lfsr_q     <= lfsr_d;
            lo_q       <= lo_d;
            span_q     <= span_d;
            try_q      <= try_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            fallback_q <= fallback_d;
        end
    end

    assign busy     = (st_q == StDraw);
    assign valid    = valid_q;
    assign dout     = dout_q;
    assign fallback = fallback_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Directed bench for lfsr_range_gen (LFSR_W=8, OUT_W=4, SEED=FF) with a MAX_TRY=1 twin.
// Expected values are hand-derived from the tap set 7,5,4,3.
module tb_lfsr_range_gen;

    logic       clk;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       req;
    logic       req1;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       busy, valid, fallback;
    logic [3:0] dout;
    logic       busy1, valid1, fallback1;
    logic [3:0] dout1;

    int errors = 0;
    int checks = 0;

    lfsr_range_gen #(
        .LFSR_W (8),
        .OUT_W  (4),
        .SEED   (32'h0000_00FF),
        .MAX_TRY(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .req      (req),
        .lo       (lo),
        .hi       (hi),
        .busy     (busy),
        .valid    (valid),
        .dout     (dout),
        .fallback (fallback)
    );

    lfsr_range_gen #(
        .LFSR_W (8),
        .OUT_W  (4),
        .SEED   (32'h0000_00FF),
        .MAX_TRY(1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed_load(1'b0),
        .seed_in  (8'h00),
        .req      (req1),
        .lo       (lo),
        .hi       (hi),
        .busy     (busy1),
        .valid    (valid1),
        .dout     (dout1),
        .fallback (fallback1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return at the following falling edge for sampling.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed_in = 8'h00; req = 1'b0; req1 = 1'b0;
        lo = 4'd0; hi = 4'd0;
        tick(); tick();
        check("rst_state", dut.lfsr_q, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_dout", dout, 4'd0);
        check("rst_fallback", fallback, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle_no_freerun", dut.lfsr_q, 8'hFF);

        // Rejection: 0..9, evaluations E, C rejected, 8 accepted.
        req = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        req = 1'b0;
        check("rej_accept_state", dut.lfsr_q, 8'hFE);
        check("rej_busy", busy, 1'b1);
        tick();
        check("rej_step1_state", dut.lfsr_q, 8'hFC);
        check("rej_step1_valid", valid, 1'b0);
        tick();
        check("rej_step2_state", dut.lfsr_q, 8'hF8);
        check("rej_step2_valid", valid, 1'b0);
        tick();
        check("rej_valid", valid, 1'b1);
        check("rej_busy_low", busy, 1'b0);
        check("rej_dout", dout, 4'd8);
        check("rej_fallback", fallback, 1'b0);
        tick();
        check("rej_valid_pulse", valid, 1'b0);
        check("rej_dout_held", dout, 4'd8);

        // Span 0 draw: one step F8->F0, cand 0.
        req = 1'b1; lo = 4'd0; hi = 4'd0;
        tick();
        req = 1'b0;
        check("seq_state_f0", dut.lfsr_q, 8'hF0);
        tick();
        check("zero_span_valid", valid, 1'b1);
        check("zero_span_dout", dout, 4'd0);

        // Back-to-back request on the valid cycle; degenerate lo=hi=3.
        req = 1'b1; lo = 4'd3; hi = 4'd3;
        tick();
        req = 1'b0;
        check("b2b_accepted", busy, 1'b1);
        check("seq_state_e1", dut.lfsr_q, 8'hE1);
        tick();
        check("degen_valid", valid, 1'b1);
        check("degen_dout", dout, 4'd3);

        // Swap from reset: lo=9,hi=2 -> base 2, mask 7, cand 6.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 1'b1; lo = 4'd9; hi = 4'd2;
        tick();
        req = 1'b0;
        tick();
        check("swap_valid", valid, 1'b1);
        check("swap_dout", dout, 4'd8);
        check("swap_fallback", fallback, 1'b0);

        // Exhaustion on the MAX_TRY=1 twin: cand 14 rejected, 14&9 = 8.
        req1 = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        req1 = 1'b0;
        check("exh_busy", busy1, 1'b1);
        tick();
        check("exh_valid", valid1, 1'b1);
        check("exh_dout", dout1, 4'd8);
        check("exh_fallback", fallback1, 1'b1);
        check("exh_busy_low", busy1, 1'b0);

        // Seed load with req in IDLE: no step, first evaluation uses seed 05.
        seed_load = 1'b1; seed_in = 8'h05; req = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        seed_load = 1'b0; req = 1'b0;
        check("ld_idle_state", dut.lfsr_q, 8'h05);
        check("ld_idle_busy", busy, 1'b1);
        tick();
        check("ld_idle_valid", valid, 1'b1);
        check("ld_idle_dout", dout, 4'd5);
        check("fallback_cleared", fallback, 1'b0);

        // Seed load during DRAW: FE -> cand E rejected, load 03 instead of stepping.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        req = 1'b0; seed_load = 1'b1; seed_in = 8'h03;
        tick();
        seed_load = 1'b0;
        check("ld_draw_state", dut.lfsr_q, 8'h03);
        check("ld_draw_busy", busy, 1'b1);
        tick();
        check("ld_draw_valid", valid, 1'b1);
        check("ld_draw_dout", dout, 4'd3);

        // Zero seed: guarded build reloads FF, plain build locks at 0.
        seed_load = 1'b1; seed_in = 8'h00;
        tick();
        seed_load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        check("zero_seed_state", dut.lfsr_q, 8'hFF);
`else
        check("zero_seed_state", dut.lfsr_q, 8'h00);
`endif
        req = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        req = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        tick(); tick();
        check("zero_seed_pre_valid", valid, 1'b0);
        tick();
        check("zero_seed_valid", valid, 1'b1);
        check("zero_seed_dout", dout, 4'd8);
`else
        tick();
        check("zero_seed_valid", valid, 1'b1);
        check("zero_seed_dout", dout, 4'd0);
        check("zero_seed_locked", dut.lfsr_q, 8'h00);
`endif

        // Reset mid-draw with req held high while busy.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 1'b1; lo = 4'd0; hi = 4'd9;
        tick();
        tick();
        check("busy_req_state", dut.lfsr_q, 8'hFC);
        check("busy_req_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_state", dut.lfsr_q, 8'hFF);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_valid", valid, 1'b0);
        check("mid_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
